button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Multi-channel input conditioner for the board push-buttons/switches feeding the game FSM.
//  Per channel: metastability synchronizer, tick-based debouncer, registered press/release
//  pulses and optional auto-repeat while held.
//  Sits between raw FPGA pins and the column-select/drop control logic; one instance serves all keys.
// PARAMETERS
//  N             4   number of independent channels
//  INV           1   1: inputs active-low (idle high); 0: active-high. Applied before sync.
//  SYNC_STAGES   2   synchronizer flops per channel, >=2
//  DEBOUNCE_TICKS 4  enable ticks a changed level must persist before acceptance, >=1
//  REPEAT_DELAY  0   enable ticks from press to first repeat pulse; 0 = auto-repeat disabled
//  REPEAT_RATE   1   enable ticks between subsequent repeat pulses, >=1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-high
//  enable     in   1  sample tick (e.g. 1 kHz strobe); gates debounce/repeat counting only
//  btn_in     in   N  raw asynchronous inputs
//  level      out  N  debounced level, normalised: 1 = active
//  press      out  N  1-clk pulse when level goes 0->1
//  release    out  N  1-clk pulse when level goes 1->0
//  repeat_p   out  N  1-clk auto-repeat pulse while level held 1
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0; sync flops load normalised idle (0); all counters 0.
//    Reset dominates at any time, including mid-debounce or mid-repeat; no pulses on deassert.
//  - Normalise: raw = btn_in ^ {N{INV}}. Sync chain shifts every clk (not gated by enable).
//  - Debounce per channel, counter width $clog2(DEBOUNCE_TICKS+1):
//    synced == level on any clk -> cnt <= 0.
//    synced != level and enable -> cnt++; on the tick where cnt == DEBOUNCE_TICKS-1:
//    level <= synced, cnt <= 0.
//    synced != level and !enable -> cnt holds.
//  - Latency (enable=1 every clk): input change before edge 0 -> level changes at edge
//    SYNC_STAGES+DEBOUNCE_TICKS.
//    Any bounce back to the old value before then restarts the count from 0.
//  - press/release: registered, asserted in the same clk that level first shows the new value;
//    exactly one clk wide. Never both in one clk for one channel.
//  - Auto-repeat (REPEAT_DELAY>0), per channel rpt_cnt:
//    cleared on the press edge and whenever level=0.
//    While level=1, each enable tick (excluding the press tick) increments it.
//    First repeat_p on tick REPEAT_DELAY after press; then every REPEAT_RATE ticks; continues
//    until release.
//    Counter wraps back to the rate phase and never saturates or overflows.
//    REPEAT_DELAY=0 -> repeat_p tied 0.
//  - Channels fully independent; simultaneous events on several channels are all reported in
//    the same clk.
//  - enable low for arbitrary time freezes debounce/repeat progress; outputs hold, no pulses.
// TESTING (N=2, INV=1, SYNC_STAGES=2, DEBOUNCE_TICKS=4, REPEAT_DELAY=8, REPEAT_RATE=3,
//          enable=1 unless stated)
//  1. rst pulse with btn_in=2'b11 -> level=press=release=repeat_p=0 during and after reset.
//  2. btn_in[0] 1->0 before edge 0, held -> level[0]=1 and press[0]=1 at edge 6 only;
//     channel 1 outputs stay 0.
//  3. btn_in[0] low 3 clks then high -> no level/press/release change on either channel.
//  4. Hold ch0 after press -> repeat_p[0] at ticks 8, 11, 14 after press.
//     Release -> release[0] pulse SYNC_STAGES+4 clks later; no repeat_p after level falls.
//  5. enable high 1 clk in 4, btn_in[1] pressed -> level[1] rises on the 4th enable tick after
//     sync (~16 clks); press[1] pulse exactly 1 clk.
//  6. Assert rst mid-hold with repeats active -> outputs 0 immediately (async).
//     Deassert with input still low -> press re-issued after 2+4 clks; first repeat 8 ticks
//     after that press.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: input capture, metastability synchronizer, tick-based
// debouncer, registered press/release pulses and optional auto-repeat while held.
module button_conditioner #(
   parameter int unsigned N              = 4,
   parameter int unsigned INV            = 1,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned REPEAT_DELAY   = 0,
   parameter int unsigned REPEAT_RATE    = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_p,
   output logic [N-1:0] repeat_p
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [N-1:0] INV_MASK = (INV != 0) ? '1 : '0;

   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

   typedef enum logic {
      RptDelay,
      RptRate
   } rpt_state_e;

   logic [N-1:0]                  raw;
   logic [N-1:0]                  in_q;
   logic [SYNC_STAGES-1:0][N-1:0] sync_q;
   logic [N-1:0]                  synced;

   assign raw    = btn_in ^ INV_MASK;
   assign synced = sync_q[SYNC_STAGES-1];

   // Pad capture register ahead of the synchronizer; runs every clock, not gated by enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q   <= '0;
         sync_q <= '0;
      end else begin
         in_q   <= raw;
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_q};
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             lvl_q, lvl_d;
      logic             press_q, rel_q, rep_q;
      logic             rpt_fire;

      always_comb begin
         cnt_d = cnt_q;
         lvl_d = lvl_q;
         if (synced[i] == lvl_q) begin
            cnt_d = '0;
         end else if (enable) begin
            if (cnt_q == DB_LAST) begin
               lvl_d = synced[i];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= lvl_d & ~lvl_q;
            rel_q   <= ~lvl_d & lvl_q;
            rep_q   <= rpt_fire;
         end
      end

      if (REPEAT_DELAY > 0) begin : g_rpt
         localparam logic [RPT_W-1:0] DELAY_W = RPT_W'(REPEAT_DELAY);
         localparam logic [RPT_W-1:0] RATE_W  = RPT_W'(REPEAT_RATE);

         rpt_state_e       state_q, state_d;
         logic [RPT_W-1:0] rcnt_q, rcnt_d;
         logic [RPT_W-1:0] rcnt_inc;
         logic [RPT_W-1:0] target;
         logic             hit;

         assign rcnt_inc = rcnt_q + 1'b1;
         assign target   = (state_q == RptDelay) ? DELAY_W : RATE_W;
         assign hit      = (rcnt_inc == target);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q <= RptDelay;
               rcnt_q  <= '0;
            end else begin
               state_q <= state_d;
               rcnt_q  <= rcnt_d;
            end
         end

         // Idle level clears the counter, which also keeps the press tick from counting.
         always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            if (!lvl_q) begin
               state_d = RptDelay;
               rcnt_d  = '0;
            end else if (enable && lvl_d) begin
               if (hit) begin
                  state_d = RptRate;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_inc;
               end
            end
         end

         always_comb begin
            rpt_fire = lvl_q & lvl_d & enable & hit;
         end
      end else begin : g_norpt
         assign rpt_fire = 1'b0;
      end

      assign level[i]     = lvl_q;
      assign press[i]     = press_q;
      assign release_p[i] = rel_q;
      assign repeat_p[i]  = rep_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, hand-written corner sequences and a
// randomized run checked every clock against a behavioural model.
module tb_button_conditioner;

   localparam int N   = 2;
   localparam int INV = 1;
   localparam int SS  = 2;
   localparam int DB  = 4;
   localparam int RD  = 8;
   localparam int RR  = 3;
   // A pin change reaches the debouncer SS+1 edges later, so DB ticks land on edge SS+DB.
   localparam int LAT = SS + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [N-1:0] btn_in;
   logic [N-1:0] level, press, release_p, repeat_p;

   int checks = 0;
   int errors = 0;

   bit           m_pipe  [N][LAT];
   int           m_run   [N];
   bit           m_lvl   [N];
   int           m_ticks [N];
   logic [N-1:0] m_level, m_press, m_rel, m_rep;

   typedef struct {
      logic [N-1:0] btn;
      logic         en;
      logic [N-1:0] lvl;
      logic [N-1:0] pr;
      logic [N-1:0] rl;
      logic [N-1:0] rp;
   } vec_t;

   vec_t tbl [22];

   button_conditioner #(
      .N              (N),
      .INV            (INV),
      .SYNC_STAGES    (SS),
      .DEBOUNCE_TICKS (DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .btn_in    (btn_in),
      .level     (level),
      .press     (press),
      .release_p (release_p),
      .repeat_p  (repeat_p)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic expect_out(input string name, input logic [N-1:0] l, input logic [N-1:0] p,
                             input logic [N-1:0] r, input logic [N-1:0] rp);
      check({name, ".level"}, int'(level), int'(l));
      check({name, ".press"}, int'(press), int'(p));
      check({name, ".release"}, int'(release_p), int'(r));
      check({name, ".repeat"}, int'(repeat_p), int'(rp));
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         for (int j = 0; j < LAT; j++) m_pipe[c][j] = 1'b0;
         m_run[c]   = 0;
         m_lvl[c]   = 1'b0;
         m_ticks[c] = 0;
      end
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_rep   = '0;
   endtask

   // One clock edge of the behavioural model, using the inputs present before the edge.
   task automatic model_edge();
      for (int c = 0; c < N; c++) begin
         bit seen, old_l, new_l;
         seen = m_pipe[c][LAT-1];
         for (int j = LAT - 1; j > 0; j--) m_pipe[c][j] = m_pipe[c][j-1];
         m_pipe[c][0] = btn_in[c] ^ (INV != 0);
         old_l = m_lvl[c];
         new_l = old_l;
         if (seen == old_l) begin
            m_run[c] = 0;
         end else if (enable) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               new_l    = seen;
               m_run[c] = 0;
            end
         end
         m_rep[c] = 1'b0;
         if (!old_l) begin
            m_ticks[c] = 0;
         end else if (enable && new_l) begin
            m_ticks[c]++;
            m_rep[c] = (m_ticks[c] >= RD) && (((m_ticks[c] - RD) % RR) == 0);
         end
         m_press[c] = new_l & ~old_l;
         m_rel[c]   = ~new_l & old_l;
         m_lvl[c]   = new_l;
         m_level[c] = new_l;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      @(negedge clk);
      check("model_level", int'(level), int'(m_level));
      check("model_press", int'(press), int'(m_press));
      check("model_release", int'(release_p), int'(m_rel));
      check("model_repeat", int'(repeat_p), int'(m_rep));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int rise_at;
      int press_cnt;

      // ch0 pressed from row 0: press at edge 6, repeats at 14, 17, 20
      for (int i = 0; i < 22; i++) begin
         tbl[i].btn = 2'b10;
         tbl[i].en  = 1'b1;
         tbl[i].lvl = (i >= 6) ? 2'b01 : 2'b00;
         tbl[i].pr  = (i == 6) ? 2'b01 : 2'b00;
         tbl[i].rl  = 2'b00;
         tbl[i].rp  = (i == 14 || i == 17 || i == 20) ? 2'b01 : 2'b00;
      end

      rst    = 1'b1;
      enable = 1'b1;
      btn_in = 2'b11;
      model_reset();
      #1;
      expect_out("reset_async", 2'b00, 2'b00, 2'b00, 2'b00);
      cycle();
      expect_out("reset_held", 2'b00, 2'b00, 2'b00, 2'b00);
      cycle();
      rst = 1'b0;
      cycle();
      expect_out("reset_after", 2'b00, 2'b00, 2'b00, 2'b00);

      for (int i = 0; i < 22; i++) begin
         btn_in = tbl[i].btn;
         enable = tbl[i].en;
         cycle();
         expect_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].pr, tbl[i].rl, tbl[i].rp);
      end

      // Release: repeats continue until level falls at edge 6, then stop.
      btn_in = 2'b11;
      for (int k = 0; k < 10; k++) begin
         cycle();
         expect_out($sformatf("release%0d", k), (k < 6) ? 2'b01 : 2'b00, 2'b00,
                    (k == 6) ? 2'b01 : 2'b00, (k == 1 || k == 4) ? 2'b01 : 2'b00);
      end

      // Short glitch never survives the debouncer.
      for (int k = 0; k < 13; k++) begin
         btn_in = (k < 3) ? 2'b10 : 2'b11;
         cycle();
         expect_out($sformatf("glitch%0d", k), 2'b00, 2'b00, 2'b00, 2'b00);
      end

      // Sparse enable: ticks at edges 4, 8, 12, 16 after the change.
      rise_at   = -1;
      press_cnt = 0;
      btn_in    = 2'b01;
      for (int k = 0; k < 40; k++) begin
         enable = (k % 4 == 0);
         cycle();
         if (level[1] && rise_at < 0) rise_at = k;
         if (press[1]) press_cnt++;
      end
      check("sparse_rise_edge", rise_at, 16);
      check("sparse_press_width", press_cnt, 1);
      check("sparse_ch0_level", int'(level[0]), 0);

      // Reset in the middle of auto-repeat.
      enable = 1'b1;
      for (int k = 0; k < 12; k++) cycle();
      #2 rst = 1'b1;
      #1;
      expect_out("reset_midhold", 2'b00, 2'b00, 2'b00, 2'b00);
      model_reset();
      cycle();
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cycle();
         expect_out($sformatf("rearm%0d", k), (k >= 6) ? 2'b10 : 2'b00,
                    (k == 6) ? 2'b10 : 2'b00, 2'b00, (k == 14) ? 2'b10 : 2'b00);
      end

      // Randomized run against the model.
      for (int c = 0; c < 3000; c++) begin
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(399) == 0) begin
            rst = 1'b1;
         end
         if ($urandom_range(15) == 0) begin
            int idx;
            idx         = $urandom_range(N - 1);
            btn_in[idx] = ~btn_in[idx];
         end
         enable = ($urandom_range(3) != 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
